// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the load/store unit: decode command codes, access
// size codes, extension select, LSU state encoding, and the alignment rule.
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        CMD_OTHER = 2'b00,
        CMD_JMP   = 2'b01,
        CMD_ST    = 2'b10,
        CMD_LW    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SZ_FULL  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_UPPER = 2'b11
    } size_e;

    localparam logic SIGN   = 1'b1;
    localparam logic UNSIGN = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } lsu_state_e;

    // UPPER has no lane mapping in a 32-bit datapath, so it never aligns.
    function automatic logic addr_aligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_FULL: addr_aligned = (lo == 2'b00);
            SZ_HALF: addr_aligned = (lo[0] == 1'b0);
            SZ_BYTE: addr_aligned = 1'b1;
            default: addr_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane steering for a 32-bit word memory.
//   size      : access size (FULL/HALF/BYTE; UPPER yields no lanes)
//   addr_lo   : byte offset within the word
//   sign      : SIGN = sign-extend load data, UNSIGN = zero-extend
//   wdata     : store data, low bytes significant
//   rdata     : raw read word from memory
//   be        : byte enables for the access
//   wdata_rep : store data replicated across all lanes
//   rdata_ext : selected load lane, extended to 32 bits
// ---------------------------------------------------------------------------
module lsu_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_e             size,
    input  logic [1:0]        addr_lo,
    input  logic              sign,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    function automatic logic [31:0] ext16(input logic signed [15:0] h, input logic s);
        ext16 = (s == UNSIGN) ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] ext8(input logic signed [7:0] b, input logic s);
        ext8 = (s == UNSIGN) ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    logic [15:0] lane_h;
    logic [7:0]  lane_b;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        lane_b    = rdata[{addr_lo, 3'b000} +: 8];
        case (size)
            SZ_FULL: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = ext16(lane_h, sign);
            end
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = ext8(lane_b, sign);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_lsu_ctrl
// Load/store sequencer between decode and a single-port data memory.
// One access in flight; req/ack handshake; pipeline stall; lane steering;
// misalignment rejection and ack timeout.
//   clk, rst_n                  : clock, async active-low reset
//   cmd_i/size_i/sign_i         : decode memory controls
//   addr_i/wdata_i/rd_i         : byte address, store data, load destination
//   mem_req_o/we/addr/be/wdata  : memory request, held stable while BUSY
//   mem_ack_i/mem_rdata_i       : memory completion and read word
//   stall_o                     : hold pipeline
//   wb_valid_o/wb_rd_o/wb_data_o: load writeback (1-cycle pulse)
//   misalign_o/timeout_o        : 1-cycle error pulses
// ---------------------------------------------------------------------------
module cpu_lsu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TO_CYC = 255,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cmd_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    lsu_state_e        state_q, state_d;
    logic [TO_W-1:0]   cnt_q;
    logic              misalign_q, timeout_q, timeout_d;

    // Request fields latched at start (_p1) and load result captured at ack (_p2).
    // These carry no reset: every output that exposes them is gated by state.
    logic [ADDR_W-1:0] addr_p1;
    logic              we_p1;
    size_e             size_p1;
    logic              sign_p1;
    logic [4:0]        rd_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [3:0]        be_p1;
    logic [DATA_W-1:0] rdata_p2;

    logic              busy, can_start, is_mem, aligned, start, bad;
    logic              at_limit, ack_busy;
    size_e             size_sel;
    logic [1:0]        lo_sel;
    logic              sign_sel;
    logic [3:0]        be_w;
    logic [DATA_W-1:0] wdata_w, rdata_w;

    assign busy      = (state_q == S_BUSY);
    assign can_start = (state_q == S_IDLE) || (state_q == S_RESP);
    assign is_mem    = (cmd_i == CMD_LW) || (cmd_i == CMD_ST);
    assign aligned   = addr_aligned(size_e'(size_i), addr_i[1:0]);
    assign start     = can_start && is_mem && aligned;
    assign bad       = can_start && is_mem && !aligned;
    assign at_limit  = (cnt_q == TO_W'(TO_CYC - 1));
    assign ack_busy  = busy && mem_ack_i;

    // One aligner serves both directions: live inputs when a request can be
    // accepted (store steering / be), latched fields while BUSY (load extend).
    assign size_sel = busy ? size_p1       : size_e'(size_i);
    assign lo_sel   = busy ? addr_p1[1:0]  : addr_i[1:0];
    assign sign_sel = busy ? sign_p1       : sign_i;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size      (size_sel),
        .addr_lo   (lo_sel),
        .sign      (sign_sel),
        .wdata     (wdata_i),
        .rdata     (mem_rdata_i),
        .be        (be_w),
        .wdata_rep (wdata_w),
        .rdata_ext (rdata_w)
    );

    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (start) begin
                    state_d = S_BUSY;
                    stall_o = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    // Ack on the limit cycle still completes normally.
                    state_d = we_p1 ? S_IDLE : S_RESP;
                end else if (at_limit) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (busy && state_d == S_BUSY) ? cnt_q + TO_W'(1) : '0;
            misalign_q <= bad;
            timeout_q  <= timeout_d;
        end
    end

    // Stage p1: request capture; stage p2: load result capture
    always_ff @(posedge clk) begin
        if (start) begin
            addr_p1  <= addr_i;
            we_p1    <= (cmd_i == CMD_ST);
            size_p1  <= size_e'(size_i);
            sign_p1  <= sign_i;
            rd_p1    <= rd_i;
            wdata_p1 <= wdata_w;
            be_p1    <= be_w;
        end
        if (ack_busy && !we_p1) begin
            rdata_p2 <= rdata_w;
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = busy && we_p1;
    assign mem_addr_o  = busy ? {addr_p1[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be_o    = busy ? be_p1 : 4'b0000;
    assign mem_wdata_o = (busy && we_p1) ? wdata_p1 : '0;

    assign wb_valid_o  = (state_q == S_RESP);
    assign wb_rd_o     = wb_valid_o ? rd_p1 : 5'd0;
    assign wb_data_o   = wb_valid_o ? rdata_p2 : '0;
    assign misalign_o  = misalign_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cpu_lsu_ctrl.sv
module tb_cpu_lsu_ctrl;

    localparam int TO_CYC = 255;

    logic        clk, rst_n;
    logic [1:0]  cmd, size;
    logic        sign;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    logic        ack;
    logic        mem_req_o, mem_we_o, stall_o, wb_valid_o, misalign_o, timeout_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  wb_rd_o;

    int errors = 0;
    int checks = 0;

    cpu_lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TO_CYC(TO_CYC), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_i(cmd), .size_i(size), .sign_i(sign), .addr_i(addr),
        .wdata_i(wdata), .rd_i(rd),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(ack), .mem_rdata_i(rdata),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        stall;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic        mis;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    localparam logic [1:0] OT = 2'b00, JP = 2'b01, ST = 2'b10, LW = 2'b11;
    localparam logic [1:0] FU = 2'b00, HA = 2'b01, BY = 2'b10, UP = 2'b11;

    function automatic vec_t row(
        input logic [1:0] c, input logic [1:0] s, input logic sg, input logic [31:0] a,
        input logic [31:0] wd, input logic [4:0] r, input logic ak, input logic [31:0] rdt,
        input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [3:0] e_be,
        input logic [31:0] e_wd, input logic e_st, input logic e_wbv, input logic [4:0] e_rd,
        input logic [31:0] e_wbd, input logic e_mis, input logic e_to);
        vec_t v;
        v.cmd = c; v.size = s; v.sign = sg; v.addr = a; v.wdata = wd; v.rd = r;
        v.ack = ak; v.rdata = rdt;
        v.req = e_req; v.we = e_we; v.maddr = e_addr; v.be = e_be; v.mwdata = e_wd;
        v.stall = e_st; v.wbv = e_wbv; v.wbrd = e_rd; v.wbdata = e_wbd;
        v.mis = e_mis; v.to = e_to;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd = OT; size = FU; sign = 1'b0; addr = '0; wdata = '0; rd = '0;
        ack = 1'b0; rdata = '0;
    endtask

    task automatic apply(input vec_t v, input int i);
        cmd = v.cmd; size = v.size; sign = v.sign; addr = v.addr;
        wdata = v.wdata; rd = v.rd; ack = v.ack; rdata = v.rdata;
        @(negedge clk);
        chk($sformatf("r%0d_req", i),    32'(mem_req_o),  32'(v.req));
        chk($sformatf("r%0d_we", i),     32'(mem_we_o),   32'(v.we));
        chk($sformatf("r%0d_addr", i),   mem_addr_o,      v.maddr);
        chk($sformatf("r%0d_be", i),     32'(mem_be_o),   32'(v.be));
        chk($sformatf("r%0d_wdata", i),  mem_wdata_o,     v.mwdata);
        chk($sformatf("r%0d_stall", i),  32'(stall_o),    32'(v.stall));
        chk($sformatf("r%0d_wbv", i),    32'(wb_valid_o), 32'(v.wbv));
        chk($sformatf("r%0d_wbrd", i),   32'(wb_rd_o),    32'(v.wbrd));
        chk($sformatf("r%0d_wbdata", i), wb_data_o,       v.wbdata);
        chk($sformatf("r%0d_mis", i),    32'(misalign_o), 32'(v.mis));
        chk($sformatf("r%0d_to", i),     32'(timeout_o),  32'(v.to));
        @(posedge clk); #1;
    endtask

    int  req_cnt;
    bit  seen_to, seen_wb;

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        //            cmd size sg addr          wdata         rd  ak rdata          req we maddr         be       mwdata        st wbv rd  wbdata        mis to
        // store byte, ack on second BUSY cycle
        tbl.push_back(row(ST, BY, 0, 32'h1003, 32'h000000AB, 0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         1, 1, 32'h1000,  4'b1000, 32'hABABABAB, 1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h0,         1, 1, 32'h1000,  4'b1000, 32'hABABABAB, 1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        // load half signed
        tbl.push_back(row(LW, HA, 1, 32'h2002, 32'h0,        5,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h81230000,  1, 0, 32'h2000,  4'b1100, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 1, 5,  32'hFFFF8123, 0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        // load half unsigned
        tbl.push_back(row(LW, HA, 0, 32'h2002, 32'h0,        5,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h81230000,  1, 0, 32'h2000,  4'b1100, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 1, 5,  32'h00008123, 0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        // misaligned full load
        tbl.push_back(row(LW, FU, 0, 32'h3001, 32'h0,        1,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        1, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        // load byte, then store issued in RESP cycle (ack there is ignored)
        tbl.push_back(row(LW, BY, 0, 32'h4001, 32'h0,        7,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h11229A44,  1, 0, 32'h4000,  4'b0010, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(ST, FU, 0, 32'h5004, 32'hDEADBEEF, 0,  1, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 1, 7,  32'h0000009A, 0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h0,         1, 1, 32'h5004,  4'b1111, 32'hDEADBEEF, 1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        // load byte signed, top lane
        tbl.push_back(row(LW, BY, 1, 32'h6003, 32'h0,        31, 0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h80FF0000,  1, 0, 32'h6000,  4'b1000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 1, 31, 32'hFFFFFF80, 0, 0));
        // jump with stray ack ignored; UPPER and odd HALF rejected; aligned HALF store
        tbl.push_back(row(JP, FU, 0, 32'h8000, 32'h0,        0,  1, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(ST, UP, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        1, 0));
        tbl.push_back(row(ST, HA, 0, 32'h7001, 32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        1, 0));
        tbl.push_back(row(ST, HA, 0, 32'h7002, 32'h1234CDEF, 0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  1, 32'h0,         1, 1, 32'h7000,  4'b1100, 32'hCDEFCDEF, 1, 0, 0,  32'h0,        0, 0));
        tbl.push_back(row(OT, FU, 0, 32'h0,    32'h0,        0,  0, 32'h0,         0, 0, 32'h0,     4'b0000, 32'h0,        0, 0, 0,  32'h0,        0, 0));

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(mem_req_o),  32'd0);
        chk("rst_stall", 32'(stall_o),    32'd0);
        chk("rst_wbv",   32'(wb_valid_o), 32'd0);
        chk("rst_mis",   32'(misalign_o), 32'd0);
        chk("rst_to",    32'(timeout_o),  32'd0);
        chk("rst_addr",  mem_addr_o,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // timeout: no ack ever
        cmd = LW; size = FU; sign = 1'b0; addr = 32'h100; rd = 5'd3;
        @(posedge clk); #1;
        idle_inputs();
        req_cnt = 0; seen_to = 1'b0; seen_wb = 1'b0;
        for (int i = 0; i < 600 && !seen_to; i++) begin
            @(negedge clk);
            if (mem_req_o) req_cnt++;
            if (wb_valid_o) seen_wb = 1'b1;
            if (timeout_o) begin
                seen_to = 1'b1;
                chk("to_pulse_req",   32'(mem_req_o), 32'd0);
                chk("to_pulse_stall", 32'(stall_o),   32'd0);
            end
        end
        chk("to_seen",       32'(seen_to), 32'd1);
        chk("to_req_cycles", req_cnt,      TO_CYC);
        chk("to_no_wb",      32'(seen_wb), 32'd0);
        @(negedge clk);
        chk("to_pulse_1cyc", 32'(timeout_o), 32'd0);
        @(posedge clk); #1;

        // ack on the final allowed cycle completes normally
        cmd = LW; size = HA; sign = 1'b0; addr = 32'h202; rd = 5'd9;
        @(posedge clk); #1;
        idle_inputs();
        repeat (TO_CYC - 1) @(posedge clk);
        #1;
        ack = 1'b1; rdata = 32'hBEEF0000;
        @(negedge clk);
        chk("lim_req_still", 32'(mem_req_o), 32'd1);
        @(posedge clk); #1;
        ack = 1'b0; rdata = '0;
        @(negedge clk);
        chk("lim_wbv",  32'(wb_valid_o), 32'd1);
        chk("lim_rd",   32'(wb_rd_o),    32'd9);
        chk("lim_data", wb_data_o,       32'h0000BEEF);
        chk("lim_to",   32'(timeout_o),  32'd0);
        @(posedge clk); #1;

        // reset while BUSY, late ack ignored
        cmd = LW; size = FU; sign = 1'b0; addr = 32'h400; rd = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        #2;
        chk("arst_pre_req", 32'(mem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(mem_req_o), 32'd0);
        chk("arst_stall", 32'(stall_o),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack = 1'b1; rdata = 32'h12345678;
        seen_wb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid_o || mem_req_o) seen_wb = 1'b1;
            @(posedge clk); #1;
            ack = 1'b0;
        end
        chk("arst_no_wb", 32'(seen_wb), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
